multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback over the shared single-ported memory and single ALU. Drives `imm_sel` into `imm_gen`, using the encodings from `imm_sel.vh`, and drives all datapath mux selects and write strobes.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `inst` in 32: instruction register output; stable from DECODE until the next fetch.
- `br_cond` in 1: branch comparator result; valid in EXEC.
- `mem_ready` in 1: memory completion; sampled only while `mem_req`=1.
- `mem_req` out 1: memory request.
- `mem_we` out 1: store request.
- `mem_addr_sel` out 1: memory address select; 0=PC, 1=ALU result.
- `ir_write` out 1: latch instruction register and old-PC register.
- `pc_write` out 1: PC write enable.
- `pc_src` out 1: PC source; 0=PC+4, 1=ALU target.
- `imm_sel` out 3: immediate format select, encoded per `imm_sel.vh`.
- `alu_src_a` out 1: ALU A operand; 0=rs1, 1=old PC.
- `alu_src_b` out 1: ALU B operand; 0=rs2, 1=immediate.
- `alu_op` out 2: 00 ADD, 01 R-funct, 10 I-funct, 11 PASS_B.
- `wb_sel` out 2: writeback source; 00 ALU, 01 MEM, 10 PC+4.
- `reg_write` out 1: register file write enable.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: sticky illegal-opcode flag (active only under the macro).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, plus TRAP under the macro.
- FETCH
  - Drives `mem_req`=1 with `mem_addr_sel`=0 (PC).
  - On `mem_ready`: `ir_write`=1, `pc_write`=1 with `pc_src`=0, next state DECODE.
  - Otherwise holds in FETCH.
- DECODE
  - Decodes `inst[6:0]` and moves to EXEC.
  - An unknown opcode moves to TRAP under the macro.
- `imm_sel` derivation, from DECODE through WB, constant per instruction:
  - OP-IMM, LOAD, JALR: I.
  - STORE: S.
  - BRANCH: B.
  - LUI, AUIPC: U.
  - JAL: J.
  - OP: I (don't-care).
- EXEC
  - OP / OP-IMM: `alu_op` 01 / 10, then WB.
  - LUI: PASS_B, then WB.
  - AUIPC: `alu_src_a`=1, ADD, then WB.
  - LOAD / STORE: ADD on rs1+imm, then MEM.
  - BRANCH: `alu_src_a`=1, ADD; `pc_write`=`br_cond`, `pc_src`=1; `retire`=1; then FETCH.
  - JAL / JALR: target = oldPC+imm (JAL) or rs1+imm (JALR); `pc_write`=1, `pc_src`=1; then WB with `wb_sel`=10.
  - FENCE / SYSTEM: NOP; `retire`=1; then FETCH.
- MEM
  - Drives `mem_req`=1, `mem_addr_sel`=1, and `mem_we`=1 for stores.
  - On `mem_ready`: LOAD goes to WB; STORE asserts `retire`=1 and goes to FETCH.
- WB
  - `reg_write`=1 and `retire`=1, then FETCH.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - rd=x0 is suppressed by the register file, not by this block.

## Timing
- Outputs are combinational from the state and `inst`; the FETCH and MEM strobes additionally depend on `mem_ready`.
- Reset cycle: all outputs 0. First cycle after reset: FETCH, `mem_req`=1.
- Handshake rules:
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable until `mem_ready` is sampled high.
  - `mem_ready` is ignored while `mem_req`=0.
  - Transfer completes in the same cycle that `mem_ready` is seen.
- Latency with zero-wait memory:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/FENCE/SYSTEM: 3 cycles.
  - Each memory wait cycle adds 1.
- Reset asserted in any state, including a pending MEM or FETCH:
  - Next cycle is FETCH-reset with all outputs 0.
  - The request is abandoned; memory must tolerate the dropped request.
- A branch that is not taken asserts no `pc_write` in EXEC; PC already holds PC+4.

## Configuration
- `ILLEGAL_TRAP_EN`
- Defined:
  - Unknown opcode goes DECODE→TRAP.
  - TRAP asserts `illegal`=1 with all other outputs 0 and holds until reset.
- Undefined:
  - Unknown opcode executes as a NOP: 3 cycles, `retire` pulses.
  - `illegal` is tied to 0 and the TRAP state is absent.

## Structure
- Package `ctrl_pkg` holds:
  - state enum;
  - RV32I opcode constants;
  - `alu_op`, `wb_sel` and source-select encodings.
- `imm_sel` encodings stay in `imm_sel.vh`, which this block includes.
- Sub-module `ctrl_decode`: combinational opcode→instruction-class decoder that also produces `imm_sel` and the illegal indication. The FSM sits in `multicycle_ctrl`.

## Test plan
- `addi` 0x00C48413, `mem_ready`=1 → `imm_sel`=I from cycle 2 on; `reg_write`, `retire`, `wb_sel`=00 in cycle 4.
- `lw`, `mem_ready` low for 2 MEM cycles → `mem_req`/`mem_addr_sel`=1 held; `reg_write` with `wb_sel`=01 in cycle 7.
- `beq` 0x00940463 → `imm_sel`=B.
  - `br_cond`=1: `pc_write`=1, `pc_src`=1 in cycle 3.
  - `br_cond`=0: no EXEC `pc_write`.
  - Both cases: `retire` in cycle 3.
- `sw` 0x0084A223 → `imm_sel`=S; `mem_we`=1 in cycle 4; `reg_write` never asserted; `retire` in cycle 4.
- Instruction 0xFFFFFFFF:
  - With `ILLEGAL_TRAP_EN`: `illegal`=1 from cycle 3, held until reset.
  - Without the macro: NOP, `retire` in cycle 3.
- `rst_n`=0 during a stalled MEM → next cycle all outputs 0; after release, FETCH with `mem_req`=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the RV32I multi-cycle controller.
//   - state_t       : FSM states (TRAP only exists when ILLEGAL_TRAP_EN is defined)
//   - inst_class_t  : instruction class produced by ctrl_decode
//   - OPC_*         : RV32I major opcodes (inst[6:0])
//   - ALU_*, WB_*, ADDR_*, PC_SRC_*, SRC_A_*, SRC_B_* : datapath select encodings
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
      ,
      ST_TRAP   = 3'd5
`endif
   } state_t;

   typedef enum logic [3:0] {
      CL_OP     = 4'd0,
      CL_OP_IMM = 4'd1,
      CL_LUI    = 4'd2,
      CL_AUIPC  = 4'd3,
      CL_LOAD   = 4'd4,
      CL_STORE  = 4'd5,
      CL_BRANCH = 4'd6,
      CL_JAL    = 4'd7,
      CL_JALR   = 4'd8,
      CL_NOP    = 4'd9
   } inst_class_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_R_FN   = 2'b01;
   localparam logic [1:0] ALU_I_FN   = 2'b10;
   localparam logic [1:0] ALU_PASS_B = 2'b11;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic ADDR_PC     = 1'b0;
   localparam logic ADDR_ALU    = 1'b1;
   localparam logic PC_SRC_PC4  = 1'b0;
   localparam logic PC_SRC_TGT  = 1'b1;
   localparam logic SRC_A_RS1   = 1'b0;
   localparam logic SRC_A_PC    = 1'b1;
   localparam logic SRC_B_RS2   = 1'b0;
   localparam logic SRC_B_IMM   = 1'b1;

endpackage

// File: rtl/imm_sel.vh
// Immediate format select encodings shared between the controller and imm_gen.
// The value picks which instruction bits imm_gen assembles into the 32-bit
// immediate.
`ifndef IMM_SEL_VH
`define IMM_SEL_VH

`define IMM_SEL_I 3'd0
`define IMM_SEL_S 3'd1
`define IMM_SEL_B 3'd2
`define IMM_SEL_U 3'd3
`define IMM_SEL_J 3'd4

`endif

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational opcode decoder for the multi-cycle controller.
// Ports:
//   opcode     in  7 : inst[6:0]
//   inst_class out   : instruction class driving the FSM
//   imm_sel    out 3 : immediate format for imm_gen (encodings from imm_sel.vh)
//   illegal_op out 1 : opcode is not an RV32I major opcode
// Unknown opcodes are classed as CL_NOP; the FSM decides whether to trap.
`include "imm_sel.vh"

module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0]  opcode,
   output inst_class_t inst_class,
   output logic [2:0]  imm_sel,
   output logic        illegal_op
);

   always_comb begin
      inst_class = CL_NOP;
      imm_sel    = `IMM_SEL_I;
      illegal_op = 1'b0;
      case (opcode)
         OPC_OP:     inst_class = CL_OP;
         OPC_OP_IMM: inst_class = CL_OP_IMM;
         OPC_LOAD:   inst_class = CL_LOAD;
         OPC_JALR:   inst_class = CL_JALR;
         OPC_STORE:  begin inst_class = CL_STORE;  imm_sel = `IMM_SEL_S; end
         OPC_BRANCH: begin inst_class = CL_BRANCH; imm_sel = `IMM_SEL_B; end
         OPC_LUI:    begin inst_class = CL_LUI;    imm_sel = `IMM_SEL_U; end
         OPC_AUIPC:  begin inst_class = CL_AUIPC;  imm_sel = `IMM_SEL_U; end
         OPC_JAL:    begin inst_class = CL_JAL;    imm_sel = `IMM_SEL_J; end
         OPC_FENCE,
         OPC_SYSTEM: inst_class = CL_NOP;
         default:    illegal_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM. Sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB over a single-ported memory and one ALU,
// driving all datapath selects, write strobes and imm_sel for imm_gen.
// Ports:
//   clk, rst_n (sync, active-low)   inst[31:0], br_cond, mem_ready
//   mem_req, mem_we, mem_addr_sel   ir_write, pc_write, pc_src, imm_sel[2:0]
//   alu_src_a, alu_src_b, alu_op[1:0], wb_sel[1:0], reg_write, retire, illegal
// Build option: ILLEGAL_TRAP_EN -- unknown opcodes enter TRAP and raise the
// sticky illegal flag; without it they retire as 3-cycle NOPs.
//
// state  | meaning
// FETCH  | read instruction at PC; on mem_ready latch IR/old PC and PC<=PC+4
// DECODE | opcode decode, imm_sel valid from here on
// EXEC   | ALU op; branches/jumps update PC; branch/NOP retire here
// MEM    | load/store data access at ALU address; store retires here
// WB     | register write and retire
// TRAP   | illegal opcode seen; only illegal=1 until reset (ILLEGAL_TRAP_EN)
module multicycle_ctrl
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        br_cond,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic [2:0]  imm_sel,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  wb_sel,
   output logic        reg_write,
   output logic        retire,
   output logic        illegal
);

   state_t      state, state_nxt;
   logic        rst_hold;
   inst_class_t cls;
   logic [2:0]  dec_imm_sel;
   logic        illegal_op;
   logic [24:0] unused_inst_hi;

   assign unused_inst_hi = inst[31:7];

   ctrl_decode u_decode (
      .opcode     (inst[6:0]),
      .inst_class (cls),
      .imm_sel    (dec_imm_sel),
      .illegal_op (illegal_op)
   );

`ifndef ILLEGAL_TRAP_EN
   logic unused_illegal_op;
   assign unused_illegal_op = illegal_op;
`endif

   // rst_hold marks the cycle right after reset is sampled: state is FETCH
   // but every output is held at 0 so an abandoned request is not reissued
   // until reset has been released.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_FETCH;
         rst_hold <= 1'b1;
      end else begin
         state    <= state_nxt;
         rst_hold <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      if (rst_hold) begin
         state_nxt = ST_FETCH;
      end else begin
         case (state)
            ST_FETCH:  if (mem_ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
               state_nxt = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
               if (illegal_op) state_nxt = ST_TRAP;
`endif
            end
            ST_EXEC: begin
               case (cls)
                  CL_LOAD, CL_STORE:    state_nxt = ST_MEM;
                  CL_BRANCH, CL_NOP:    state_nxt = ST_FETCH;
                  default:              state_nxt = ST_WB;
               endcase
            end
            ST_MEM:    if (mem_ready) state_nxt = (cls == CL_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:     state_nxt = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:   state_nxt = ST_TRAP;
`endif
            default:   state_nxt = ST_FETCH;
         endcase
      end
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = ADDR_PC;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_PC4;
      imm_sel      = 3'd0;
      alu_src_a    = SRC_A_RS1;
      alu_src_b    = SRC_B_RS2;
      alu_op       = ALU_ADD;
      wb_sel       = WB_ALU;
      reg_write    = 1'b0;
      retire       = 1'b0;
      illegal      = 1'b0;
      if (!rst_hold) begin
         case (state)
            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            ST_DECODE: imm_sel = dec_imm_sel;
            ST_EXEC: begin
               imm_sel = dec_imm_sel;
               case (cls)
                  CL_OP:     alu_op = ALU_R_FN;
                  CL_OP_IMM: begin alu_src_b = SRC_B_IMM; alu_op = ALU_I_FN; end
                  CL_LUI:    begin alu_src_b = SRC_B_IMM; alu_op = ALU_PASS_B; end
                  CL_AUIPC:  begin alu_src_a = SRC_A_PC; alu_src_b = SRC_B_IMM; end
                  CL_LOAD,
                  CL_STORE:  alu_src_b = SRC_B_IMM;
                  CL_BRANCH: begin
                     alu_src_a = SRC_A_PC;
                     alu_src_b = SRC_B_IMM;
                     pc_write  = br_cond;
                     pc_src    = PC_SRC_TGT;
                     retire    = 1'b1;
                  end
                  CL_JAL, CL_JALR: begin
                     alu_src_a = (cls == CL_JAL) ? SRC_A_PC : SRC_A_RS1;
                     alu_src_b = SRC_B_IMM;
                     pc_write  = 1'b1;
                     pc_src    = PC_SRC_TGT;
                  end
                  default:   retire = 1'b1;
               endcase
            end
            ST_MEM: begin
               imm_sel      = dec_imm_sel;
               mem_req      = 1'b1;
               mem_addr_sel = ADDR_ALU;
               mem_we       = (cls == CL_STORE);
               retire       = mem_ready && (cls == CL_STORE);
            end
            ST_WB: begin
               imm_sel   = dec_imm_sel;
               reg_write = 1'b1;
               retire    = 1'b1;
               if (cls == CL_LOAD)                        wb_sel = WB_MEM;
               else if (cls == CL_JAL || cls == CL_JALR)  wb_sel = WB_PC4;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:   illegal = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Outputs are packed into an 18-bit vector
// {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, imm_sel[2:0],
//  alu_src_a, alu_src_b, alu_op[1:0], wb_sel[1:0], reg_write, retire, illegal}
// and compared per cycle under a mask that skips fields left open in that state.
module tb_multicycle_ctrl;

   logic        clk, rst_n, br_cond, mem_ready;
   logic [31:0] inst;
   logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
   logic [2:0]  imm_sel;
   logic        alu_src_a, alu_src_b;
   logic [1:0]  alu_op, wb_sel;
   logic        reg_write, retire, illegal;

   int checks   = 0;
   int failures = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .br_cond(br_cond), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .imm_sel(imm_sel),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel),
      .reg_write(reg_write), .retire(retire), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [2:0] IM_I = 3'd0, IM_S = 3'd1, IM_B = 3'd2, IM_U = 3'd3, IM_J = 3'd4;

   localparam logic [17:0] MK_ALL = 18'h3FFFF;
   localparam logic [17:0] MK_F   = 18'h3F007;
   localparam logic [17:0] MK_D   = 18'h3FE07;
   localparam logic [17:0] MK_E   = 18'h3FFE7;
   localparam logic [17:0] MK_W   = 18'h3FE1F;
   localparam logic [17:0] NO_IMM = 18'h3F1FF;

   typedef struct packed {
      logic        rdy;
      logic        bc;
      logic [17:0] m;
      logic [17:0] e;
   } step_t;

   function automatic logic [17:0] obs();
      return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, imm_sel,
              alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, retire, illegal};
   endfunction

   function automatic logic [17:0] mk(logic req, logic we, logic asel, logic irw, logic pcw,
                                      logic pcs, logic [2:0] imm, logic a, logic b,
                                      logic [1:0] aop, logic [1:0] wb, logic rw,
                                      logic ret, logic ill);
      return {req, we, asel, irw, pcw, pcs, imm, a, b, aop, wb, rw, ret, ill};
   endfunction

   function automatic step_t st(logic r, logic b, logic [17:0] m, logic [17:0] e);
      step_t s;
      s.rdy = r; s.bc = b; s.m = m; s.e = e;
      return s;
   endfunction

   function automatic logic [17:0] f_done();
      return mk(1,0,0,1,1,0,IM_I,0,0,2'b00,2'b00,0,0,0);
   endfunction

   function automatic logic [17:0] f_wait();
      return mk(1,0,0,0,0,0,IM_I,0,0,2'b00,2'b00,0,0,0);
   endfunction

   function automatic logic [17:0] dec(logic [2:0] imm);
      return mk(0,0,0,0,0,0,imm,0,0,2'b00,2'b00,0,0,0);
   endfunction

   // Leaves the DUT in its post-reset hold cycle with rst_n already released.
   task automatic reset_dut();
      rst_n = 1'b0; mem_ready = 1'b0; br_cond = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic next_cycle(input logic rdy, input logic bc);
      @(posedge clk); #1;
      mem_ready = rdy; br_cond = bc;
      #3;
   endtask

   task automatic test_reset();
      inst = 32'h00C48413;
      rst_n = 1'b0; mem_ready = 1'b1; br_cond = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #4;
         checks++;
         if (obs() !== 18'h0) begin
            failures++;
            $display("FAIL reset_zero cyc%0d: got %05h want %05h", i, obs(), 18'h0);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         next_cycle(1'b0, 1'b0);
         checks++;
         if ((obs() & MK_F) !== (f_wait() & MK_F)) begin
            failures++;
            $display("FAIL reset_first_fetch cyc%0d: got %05h want %05h", i+1, obs(), f_wait());
         end
      end
   endtask

   task automatic test_addi();
      step_t s[$];
      inst = 32'h00C48413;
      s = {st(1,0,MK_F,f_done()),
           st(1,0,MK_D,dec(IM_I)),
           st(1,0,MK_E,mk(0,0,0,0,0,0,IM_I,0,1,2'b10,2'b00,0,0,0)),
           st(1,0,MK_W,mk(0,0,0,0,0,0,IM_I,0,0,2'b00,2'b00,1,1,0)),
           st(0,0,MK_F,f_wait())};
      reset_dut();
      foreach (s[i]) begin
         next_cycle(s[i].rdy, s[i].bc);
         checks++;
         if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
            failures++;
            $display("FAIL addi cyc%0d: got %05h want %05h mask %05h", i+1, obs(), s[i].e, s[i].m);
         end
      end
   endtask

   task automatic test_load_wait();
      step_t s[$];
      logic [17:0] mv;
      inst = 32'h0004A403;
      mv = mk(1,0,1,0,0,0,IM_I,0,0,2'b00,2'b00,0,0,0);
      s = {st(1,0,MK_F,f_done()),
           st(1,0,MK_D,dec(IM_I)),
           st(1,0,MK_E,mk(0,0,0,0,0,0,IM_I,0,1,2'b00,2'b00,0,0,0)),
           st(0,0,MK_D,mv),
           st(0,0,MK_D,mv),
           st(1,0,MK_D,mv),
           st(0,0,MK_W,mk(0,0,0,0,0,0,IM_I,0,0,2'b00,2'b01,1,1,0)),
           st(0,0,MK_F,f_wait())};
      reset_dut();
      foreach (s[i]) begin
         next_cycle(s[i].rdy, s[i].bc);
         checks++;
         if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
            failures++;
            $display("FAIL lw_wait cyc%0d: got %05h want %05h mask %05h", i+1, obs(), s[i].e, s[i].m);
         end
      end
   endtask

   task automatic test_branch();
      step_t s[$];
      logic  taken;
      inst = 32'h00940463;
      for (int k = 0; k < 2; k++) begin
         taken = (k == 0);
         s = {st(1,0,MK_F,f_done()),
              st(1,!taken,MK_D,dec(IM_B)),
              st(1,taken,MK_E,mk(0,0,0,0,taken,1,IM_B,1,1,2'b00,2'b00,0,1,0)),
              st(0,0,MK_F,f_wait())};
         reset_dut();
         foreach (s[i]) begin
            next_cycle(s[i].rdy, s[i].bc);
            checks++;
            if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
               failures++;
               $display("FAIL beq_taken%0d cyc%0d: got %05h want %05h mask %05h",
                        taken, i+1, obs(), s[i].e, s[i].m);
            end
         end
      end
   endtask

   task automatic test_store();
      step_t s[$];
      inst = 32'h0084A223;
      s = {st(1,0,MK_F,f_done()),
           st(1,0,MK_D,dec(IM_S)),
           st(1,0,MK_E,mk(0,0,0,0,0,0,IM_S,0,1,2'b00,2'b00,0,0,0)),
           st(1,0,MK_D,mk(1,1,1,0,0,0,IM_S,0,0,2'b00,2'b00,0,1,0)),
           st(0,0,MK_F,f_wait())};
      reset_dut();
      foreach (s[i]) begin
         next_cycle(s[i].rdy, s[i].bc);
         checks++;
         if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
            failures++;
            $display("FAIL sw cyc%0d: got %05h want %05h mask %05h", i+1, obs(), s[i].e, s[i].m);
         end
      end
   endtask

   task automatic test_jumps();
      step_t s[$];
      inst = 32'h008000EF;
      s = {st(0,0,MK_F,f_wait()),
           st(1,0,MK_F,f_done()),
           st(1,0,MK_D,dec(IM_J)),
           st(1,0,MK_E,mk(0,0,0,0,1,1,IM_J,1,1,2'b00,2'b00,0,0,0)),
           st(1,0,MK_W,mk(0,0,0,0,0,0,IM_J,0,0,2'b00,2'b10,1,1,0)),
           st(0,0,MK_F,f_wait())};
      reset_dut();
      foreach (s[i]) begin
         next_cycle(s[i].rdy, s[i].bc);
         checks++;
         if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
            failures++;
            $display("FAIL jal cyc%0d: got %05h want %05h mask %05h", i+1, obs(), s[i].e, s[i].m);
         end
      end
      inst = 32'h000480E7;
      s = {st(1,0,MK_F,f_done()),
           st(1,0,MK_D,dec(IM_I)),
           st(1,0,MK_E,mk(0,0,0,0,1,1,IM_I,0,1,2'b00,2'b00,0,0,0)),
           st(1,0,MK_W,mk(0,0,0,0,0,0,IM_I,0,0,2'b00,2'b10,1,1,0)),
           st(0,0,MK_F,f_wait())};
      reset_dut();
      foreach (s[i]) begin
         next_cycle(s[i].rdy, s[i].bc);
         checks++;
         if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
            failures++;
            $display("FAIL jalr cyc%0d: got %05h want %05h mask %05h", i+1, obs(), s[i].e, s[i].m);
         end
      end
   endtask

   // lui, auipc, add: differ only in EXEC operand/op selects and imm format.
   task automatic test_alu_classes();
      step_t       s[$];
      logic [31:0] ins  [3];
      logic [2:0]  imm  [3];
      logic        a    [3];
      logic        b    [3];
      logic [1:0]  aop  [3];
      logic [17:0] im   [3];
      ins = '{32'h123452B7, 32'h00001297, 32'h009402B3};
      imm = '{IM_U, IM_U, IM_I};
      a   = '{1'b0, 1'b1, 1'b0};
      b   = '{1'b1, 1'b1, 1'b0};
      aop = '{2'b11, 2'b00, 2'b01};
      im  = '{MK_ALL, MK_ALL, NO_IMM};
      for (int k = 0; k < 3; k++) begin
         inst = ins[k];
         s = {st(1,0,MK_F,f_done()),
              st(1,0,MK_D & im[k],dec(imm[k])),
              st(1,0,MK_E & im[k],mk(0,0,0,0,0,0,imm[k],a[k],b[k],aop[k],2'b00,0,0,0)),
              st(1,0,MK_W & im[k],mk(0,0,0,0,0,0,imm[k],0,0,2'b00,2'b00,1,1,0)),
              st(0,0,MK_F,f_wait())};
         reset_dut();
         foreach (s[i]) begin
            next_cycle(s[i].rdy, s[i].bc);
            checks++;
            if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
               failures++;
               $display("FAIL alu_class%0d cyc%0d: got %05h want %05h mask %05h",
                        k, i+1, obs(), s[i].e, s[i].m);
            end
         end
      end
   endtask

   task automatic test_nop();
      step_t       s[$];
      logic [31:0] ins [2];
      ins = '{32'h0000000F, 32'h00000073};
      for (int k = 0; k < 2; k++) begin
         inst = ins[k];
         s = {st(1,0,MK_F,f_done()),
              st(1,0,MK_D & NO_IMM,dec(IM_I)),
              st(1,0,MK_D & NO_IMM,mk(0,0,0,0,0,0,IM_I,0,0,2'b00,2'b00,0,1,0)),
              st(0,0,MK_F,f_wait())};
         reset_dut();
         foreach (s[i]) begin
            next_cycle(s[i].rdy, s[i].bc);
            checks++;
            if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
               failures++;
               $display("FAIL fence_system%0d cyc%0d: got %05h want %05h mask %05h",
                        k, i+1, obs(), s[i].e, s[i].m);
            end
         end
      end
   endtask

   task automatic test_illegal();
      step_t s[$];
      inst = 32'hFFFFFFFF;
`ifdef ILLEGAL_TRAP_EN
      s = {st(1,0,MK_F,f_done()),
           st(1,0,MK_D & NO_IMM,dec(IM_I)),
           st(1,0,MK_ALL,mk(0,0,0,0,0,0,3'd0,0,0,2'b00,2'b00,0,0,1)),
           st(1,1,MK_ALL,mk(0,0,0,0,0,0,3'd0,0,0,2'b00,2'b00,0,0,1)),
           st(1,0,MK_ALL,mk(0,0,0,0,0,0,3'd0,0,0,2'b00,2'b00,0,0,1))};
`else
      s = {st(1,0,MK_F,f_done()),
           st(1,0,MK_D & NO_IMM,dec(IM_I)),
           st(1,0,MK_D & NO_IMM,mk(0,0,0,0,0,0,IM_I,0,0,2'b00,2'b00,0,1,0)),
           st(0,0,MK_F,f_wait())};
`endif
      reset_dut();
      foreach (s[i]) begin
         next_cycle(s[i].rdy, s[i].bc);
         checks++;
         if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
            failures++;
            $display("FAIL illegal cyc%0d: got %05h want %05h mask %05h", i+1, obs(), s[i].e, s[i].m);
         end
      end
      reset_dut();
      #3;
      checks++;
      if (obs() !== 18'h0) begin
         failures++;
         $display("FAIL illegal_reset_clear: got %05h want %05h", obs(), 18'h0);
      end
   endtask

   task automatic test_reset_in_mem();
      step_t       s[$];
      logic [17:0] mv;
      inst = 32'h0004A403;
      mv = mk(1,0,1,0,0,0,IM_I,0,0,2'b00,2'b00,0,0,0);
      s = {st(1,0,MK_F,f_done()),
           st(1,0,MK_D,dec(IM_I)),
           st(1,0,MK_E,mk(0,0,0,0,0,0,IM_I,0,1,2'b00,2'b00,0,0,0)),
           st(0,0,MK_D,mv)};
      reset_dut();
      foreach (s[i]) begin
         next_cycle(s[i].rdy, s[i].bc);
         checks++;
         if ((obs() & s[i].m) !== (s[i].e & s[i].m)) begin
            failures++;
            $display("FAIL rst_mem_pre cyc%0d: got %05h want %05h mask %05h", i+1, obs(), s[i].e, s[i].m);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      #3;
      checks++;
      if (obs() !== 18'h0) begin
         failures++;
         $display("FAIL rst_mem_zero: got %05h want %05h", obs(), 18'h0);
      end
      rst_n = 1'b1;
      next_cycle(1'b0, 1'b0);
      checks++;
      if ((obs() & MK_F) !== (f_wait() & MK_F)) begin
         failures++;
         $display("FAIL rst_mem_refetch: got %05h want %05h", obs(), f_wait());
      end
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; br_cond = 1'b0; inst = 32'h0;
      test_reset();
      test_addi();
      test_load_wait();
      test_branch();
      test_store();
      test_jumps();
      test_alu_classes();
      test_nop();
      test_illegal();
      test_reset_in_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
